// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned LATENCY_DEFAULT = 2;
  localparam int unsigned CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DATA    = 2'd1,
    FETCH   = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/arb_wait_counter.sv
// Memory wait counter: clears on load, counts 0..LATENCY-1 while enabled and wraps.
module arb_wait_counter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned LATENCY = LATENCY_DEFAULT
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(LATENCY - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == TC);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises MEM-stage data and instruction fetch onto one fixed-latency memory.
// MEMARB_ALIGN_CHECK_EN: suppress misaligned accesses and raise sticky err.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned LATENCY = LATENCY_DEFAULT,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic [31:0]       dm_rdata,
  output logic              dm_ready,
  output logic              stall_out,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              err
);

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  arb_state_e        state_q, state_d;
  logic              lat_if_q, lat_dm_q, lat_we_q;
  logic [ADDR_W-1:0] lat_if_addr_q, lat_dm_addr_q;
  logic [31:0]       lat_wdata_q;
  logic [31:0]       if_rdata_q, dm_rdata_q;
  logic              any_req, in_access, tc, mis, done, cnt_load;

  assign any_req   = if_req | dm_req;
  assign in_access = (state_q == DATA) || (state_q == FETCH);

`ifdef MEMARB_ALIGN_CHECK_EN
  logic err_q;
  assign mis = ((state_q == DATA)  && (lat_dm_addr_q[1:0] != 2'b00)) ||
               ((state_q == FETCH) && (lat_if_addr_q[1:0] != 2'b00));
  assign err = err_q;
`else
  assign mis = 1'b0;
  assign err = 1'b0;
`endif

  // A suppressed access still occupies its slot for one cycle.
  assign done     = tc | mis;
  assign cnt_load = (state_d != state_q);

  arb_wait_counter #(.LATENCY(LATENCY)) u_wait (
    .clk_i   (clk),
    .reset_i (reset),
    .load_i  (cnt_load),
    .en_i    (in_access),
    .tc_o    (tc)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = dm_req ? DATA : FETCH;
      DATA:    if (done)    state_d = lat_if_q ? FETCH : RELEASE;
      FETCH:   if (done)    state_d = RELEASE;
      RELEASE:              state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_en    = in_access && !mis;
    mem_we    = (state_q == DATA) && lat_we_q && !mis;
`ifdef MEMARB_ALIGN_CHECK_EN
    mem_addr  = (state_q == DATA) ? lat_dm_addr_q : lat_if_addr_q;
`else
    mem_addr  = ((state_q == DATA) ? lat_dm_addr_q : lat_if_addr_q) & WORD_MASK;
`endif
    mem_wdata = lat_wdata_q;
    if_ready  = (state_q == RELEASE) && lat_if_q;
    dm_ready  = (state_q == RELEASE) && lat_dm_q;
    stall_out = !reset && (((state_q == IDLE) && any_req) || in_access);
  end

  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      lat_if_q      <= 1'b0;
      lat_dm_q      <= 1'b0;
      lat_we_q      <= 1'b0;
      lat_if_addr_q <= '0;
      lat_dm_addr_q <= '0;
      lat_wdata_q   <= '0;
      if_rdata_q    <= '0;
      dm_rdata_q    <= '0;
`ifdef MEMARB_ALIGN_CHECK_EN
      err_q         <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && any_req) begin
        lat_if_q      <= if_req;
        lat_dm_q      <= dm_req;
        lat_we_q      <= dm_we;
        lat_if_addr_q <= if_addr;
        lat_dm_addr_q <= dm_addr;
        lat_wdata_q   <= dm_wdata;
      end
      if ((state_q == DATA) && tc && !lat_we_q && !mis) dm_rdata_q <= mem_rdata;
      if ((state_q == FETCH) && tc && !mis)             if_rdata_q <= mem_rdata;
`ifdef MEMARB_ALIGN_CHECK_EN
      if (mis) err_q <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: LATENCY=2 vector table plus LATENCY=1 back-to-back fetches.
module tb_mem_arbiter;

  localparam int unsigned L2 = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // LATENCY=2 instance
  logic        a_if_req, a_dm_req, a_dm_we;
  logic [31:0] a_if_addr, a_dm_addr, a_dm_wdata;
  logic [31:0] a_if_rdata, a_dm_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_if_ready, a_dm_ready, a_stall, a_mem_en, a_mem_we, a_err;

  // LATENCY=1 instance
  logic        b_if_req, b_dm_req, b_dm_we;
  logic [31:0] b_if_addr, b_dm_addr, b_dm_wdata;
  logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_if_ready, b_dm_ready, b_stall, b_mem_en, b_mem_we, b_err;

  int unsigned ncmp = 0;
  int unsigned nfail = 0;

  logic [31:0] if_q[$];
  logic [31:0] dm_q[$];
  logic [31:0] dm_hold;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    case (a)
      32'h0040_0000: mem_f = 32'h2008_0005;
      32'h1000_0010: mem_f = 32'hDEAD_BEEF;
      default:       mem_f = {a[15:0], ~a[15:0]};
    endcase
  endfunction

  assign a_mem_rdata = mem_f(a_mem_addr);
  assign b_mem_rdata = mem_f(b_mem_addr);

  mem_arbiter #(.LATENCY(2), .ADDR_W(32)) u2 (
    .clk(clk), .reset(rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_ready(a_if_ready),
    .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
    .dm_rdata(a_dm_rdata), .dm_ready(a_dm_ready), .stall_out(a_stall),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .err(a_err)
  );

  mem_arbiter #(.LATENCY(1), .ADDR_W(32)) u1 (
    .clk(clk), .reset(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ready(b_if_ready),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_rdata(b_dm_rdata), .dm_ready(b_dm_ready), .stall_out(b_stall),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .err(b_err)
  );

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_sup;
    int unsigned exp_stall;
    int unsigned exp_en;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int unsigned stall_n = 0;
    int unsigned en_n = 0;
    int unsigned dm_slots;
    bit          seen = 1'b0;
    logic [31:0] exp_addr;
    dm_slots = (v.dm_req && !v.dm_sup) ? L2 : 0;
    @(posedge clk); #1;
    a_if_req = v.if_req;  a_if_addr = v.if_addr;
    a_dm_req = v.dm_req;  a_dm_we = v.dm_we;
    a_dm_addr = v.dm_addr; a_dm_wdata = v.dm_wdata;
    if (v.if_req) if_q.push_back(mem_f(v.if_addr & 32'hFFFF_FFFC));
    if (v.dm_req) begin
      if (!v.dm_we && !v.dm_sup) dm_hold = mem_f(v.dm_addr & 32'hFFFF_FFFC);
      dm_q.push_back(dm_hold);
    end
    for (int c = 0; c < 64 && !seen; c++) begin
      @(negedge clk);
      if (a_stall) stall_n++;
      if (a_mem_en) begin
        exp_addr = ((en_n < dm_slots) ? v.dm_addr : v.if_addr) & 32'hFFFF_FFFC;
        chk("mem_addr", a_mem_addr, exp_addr);
        chk("mem_we", {31'b0, a_mem_we}, {31'b0, (en_n < dm_slots) ? v.dm_we : 1'b0});
        if (a_mem_we) chk("mem_wdata", a_mem_wdata, v.dm_wdata);
        en_n++;
      end
      if (a_if_ready || a_dm_ready) begin
        seen = 1'b1;
        chk("if_ready", {31'b0, a_if_ready}, {31'b0, v.if_req});
        chk("dm_ready", {31'b0, a_dm_ready}, {31'b0, v.dm_req});
        chk("stall_at_release", {31'b0, a_stall}, 32'd0);
        if (a_if_ready) begin
          if (if_q.size() == 0) chk("if_scoreboard_empty", 32'd1, 32'd0);
          else chk("if_rdata", a_if_rdata, if_q.pop_front());
        end
        if (a_dm_ready) begin
          if (dm_q.size() == 0) chk("dm_scoreboard_empty", 32'd1, 32'd0);
          else chk("dm_rdata", a_dm_rdata, dm_q.pop_front());
        end
      end
      if (c == 1) begin
        // the arbiter has latched by now; later input changes must be ignored
        a_if_req = 1'b0; a_dm_req = 1'b0; a_dm_we = ~v.dm_we;
        a_if_addr = 32'hFFFF_FFF0; a_dm_addr = 32'hEEEE_EEE0; a_dm_wdata = 32'h0BAD_0BAD;
      end
    end
    if (!seen) chk("ready_timeout", 32'd1, 32'd0);
    chk("stall_cycles", stall_n, v.exp_stall);
    chk("mem_en_cycles", en_n, v.exp_en);
  endtask

  initial begin
    int unsigned cyc, last, n, stall_n, en_n;

    vt[0] = '{1'b1, 32'h0040_0000, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0, 3, 2};
    vt[1] = '{1'b1, 32'h0040_0004, 1'b1, 1'b0, 32'h1000_0010, 32'h0,         1'b0, 5, 4};
    vt[2] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h1000_0020, 32'h1234_5678, 1'b0, 3, 2};
    vt[3] = '{1'b1, 32'h0040_0008, 1'b1, 1'b1, 32'h1000_0024, 32'hCAFE_F00D, 1'b0, 5, 4};
`ifdef MEMARB_ALIGN_CHECK_EN
    vt[4] = '{1'b1, 32'h0040_0000, 1'b1, 1'b0, 32'h1000_0002, 32'h0,         1'b1, 4, 2};
`else
    vt[4] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h1000_0032, 32'h0,         1'b0, 3, 2};
`endif
    vt[5] = '{1'b1, 32'h0040_000C, 1'b1, 1'b0, 32'h1000_0040, 32'h0,         1'b0, 5, 4};

    dm_hold = 32'h0;
    rst = 1'b1;
    a_if_req = 1'b1; a_dm_req = 1'b1; a_dm_we = 1'b0;
    a_if_addr = 32'h0; a_dm_addr = 32'h0; a_dm_wdata = 32'h0;
    b_if_req = 1'b0; b_dm_req = 1'b0; b_dm_we = 1'b0;
    b_if_addr = 32'h0; b_dm_addr = 32'h0; b_dm_wdata = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'b0, a_stall}, 32'd0);
    chk("rst_mem_en", {31'b0, a_mem_en}, 32'd0);
    chk("rst_readies", {30'b0, a_if_ready, a_dm_ready}, 32'd0);
    chk("rst_if_rdata", a_if_rdata, 32'd0);
    chk("rst_dm_rdata", a_dm_rdata, 32'd0);
    chk("rst_err", {31'b0, a_err}, 32'd0);
    a_if_req = 1'b0; a_dm_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vt[i]);
`ifdef MEMARB_ALIGN_CHECK_EN
    chk("err_sticky", {31'b0, a_err}, 32'd1);
`else
    chk("err_tied", {31'b0, a_err}, 32'd0);
`endif

    // reset during the second DATA cycle abandons the access
    @(posedge clk); #1;
    a_if_req = 1'b1; a_if_addr = 32'h0040_0010;
    a_dm_req = 1'b1; a_dm_we = 1'b0; a_dm_addr = 32'h1000_0010;
    @(posedge clk); #1;
    a_if_req = 1'b0; a_dm_req = 1'b0;
    @(posedge clk); #1;
    chk("data_c1_mem_en", {31'b0, a_mem_en}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_hold_stall", {31'b0, a_stall}, 32'd0);
    @(negedge clk);
    chk("post_rst_mem_en", {31'b0, a_mem_en}, 32'd0);
    chk("post_rst_stall", {31'b0, a_stall}, 32'd0);
    chk("post_rst_readies", {30'b0, a_if_ready, a_dm_ready}, 32'd0);
    chk("post_rst_if_rdata", a_if_rdata, 32'd0);
    chk("post_rst_dm_rdata", a_dm_rdata, 32'd0);
    chk("post_rst_err", {31'b0, a_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    dm_hold = 32'h0;
    run_vec(vt[1]);

    // LATENCY=1: fetches 0x0, 0x4, 0x8 back to back
    @(posedge clk); #1;
    b_if_req = 1'b1; b_if_addr = 32'h0;
    cyc = 0; last = 0; n = 0; stall_n = 0; en_n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      @(negedge clk);
      cyc++;
      if (b_stall) stall_n++;
      if (b_mem_en) en_n++;
      if (b_if_ready) begin
        chk("b2b_if_rdata", b_if_rdata, mem_f(n * 4));
        if (n == 0) chk("b2b_first_ready", cyc, 32'd3);
        else        chk("b2b_period", cyc - last, 32'd3);
        last = cyc;
        n++;
        b_if_addr = n * 4;
        if (n == 3) b_if_req = 1'b0;
      end
    end
    chk("b2b_count", n, 32'd3);
    chk("b2b_stall_cycles", stall_n, 32'd6);
    chk("b2b_mem_en_cycles", en_n, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
